knn_core_unit: RTL and testbench
================================

# knn_core_unit

Streaming k-nearest-neighbour selector for the KNN accelerator datapath (`knn_core`). A fixed test point A is compared against a stream of labelled training points B. The block computes the squared Euclidean distance for each B and keeps a distance-sorted list of the N closest neighbours. It exposes their labels, nearest first, as a packed vector for the surrounding peripheral or software to vote on.

## Interface
Parameters:
- DATA_W, default 32 (`DATA_W`): point width, {x[31:16], y[15:0]}, each coordinate unsigned 16-bit.
- LABEL, default 8 (`LABEL`): label width.
- N_NEIGHBOUR, default 4 (`N_Neighbour`): number of neighbours kept.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  run enable; low clears the neighbour list.
- valid  in  1  B/label qualifier.
- A  in  DATA_W  test point {Ax, Ay}.
- B  in  DATA_W  training point {Bx, By}.
- label  in  LABEL  class label of B.
- Neighbour_info  out  LABEL*N_NEIGHBOUR  labels of the sorted list; slot i at [LABEL*i +: LABEL], slot 0 = nearest.

## Operation
- Distance, combinational: dx = |Ax-Bx|, dy = |Ay-By| (16-bit unsigned magnitudes); dist = dx*dx + dy*dy, held at 33 bits with no overflow or truncation.
- State: N_NEIGHBOUR slots, each {occupied bit, dist[32:0], label[LABEL-1:0]}. Occupied slots are contiguous from slot 0 and sorted by ascending dist.
- Insert condition: start=1 and valid=1 at a rising clk edge.
- Insert position p: the first slot that is empty, or whose dist is strictly greater than the new dist.
  - Slots at or above p shift up by one; the last slot's old content is dropped.
  - The new entry is written to p.
  - Ties: the new entry goes after existing equal-distance entries, so the list stays stable (older sample wins).
- No insertion slot (list full, new dist ≥ every stored dist): the sample is discarded and the list is unchanged.
- Clear: when start=0 at a rising edge, all slots become empty (occupied=0, dist=0, label=0). Clear takes priority over valid.
- start=1, valid=0: list holds.
- A is sampled every insert. A may change between samples; changing A does not re-sort existing entries.
- Empty slots output label 0 on Neighbour_info.
- Insertion must be single-cycle. Use parallel per-slot compare and shift, not a sequential sort.

## Timing
- Reset (rst=0, asynchronous): all slots empty and Neighbour_info = 0 immediately. This overrides any operation in progress.
- Neighbour_info is driven from registers, not combinationally from inputs.
- Latency: a sample accepted at edge k appears in Neighbour_info just after edge k. Throughput is one sample per clock, with no stall or backpressure.
- Clear latency: after the first edge with start=0, Neighbour_info = 0.
- Deasserting start shortly after an edge leaves the outputs of that edge readable until the next edge.
- Inputs must be stable around the rising edge. No handshake output is provided.

## Test plan
- Reset: hold rst=0 with random inputs -> Neighbour_info=0. Release rst, start=0 for 5 cycles -> still 0.
- Basic sort: A={10,10}, start=1, valid=1, one sample per cycle:
  - B={11,11} L1 (dist 2)
  - B={15,15} L2 (dist 50)
  - B={12,12} L1 (dist 8)
  - B={12,10} L1 (dist 4)
  - Required after the 4th edge: slot0..3 labels = 1,1,1,2, i.e. distances 2,4,8,50.
- Overflow/discard: continue from the basic-sort list.
  - Insert dist 100 (B={20,10} L3) -> unchanged.
  - Insert dist 0 (B={10,10} L5) -> labels 5,1,1,1; the dist-50 entry is dropped.
- Ties and valid gating: insert dist 4 as L7, then dist 4 as L9 -> L7 before L9. Then a cycle with valid=0 and a closer B -> no change.
- Clear and extremes: drop start for one edge -> Neighbour_info=0. Restart with A={0,0}, B={65535,65535} L4 -> slot0=4, dist 0x1FFFC0002 with no wrap, other slots 0.
- Async reset mid-stream: assert rst=0 between edges after 2 inserts -> Neighbour_info=0 without waiting for a clock edge.

Source files
------------

// File: rtl/knn_core_unit.sv
// Streaming k-nearest-neighbour selector: keeps the N closest training points to A, sorted by distance.
// Latency: a sample accepted at a rising edge is visible on Neighbour_info just after that edge.
// Backpressure: none; one sample per clock is always accepted (or discarded if it does not fit).
module knn_core_unit #(
  parameter int DATA_W      = 32,
  parameter int LABEL       = 8,
  parameter int N_NEIGHBOUR = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          valid,
  input  logic [DATA_W-1:0]             A,
  input  logic [DATA_W-1:0]             B,
  input  logic [LABEL-1:0]              label,
  output logic [LABEL*N_NEIGHBOUR-1:0]  Neighbour_info
);

  localparam int CW = DATA_W / 2;   // coordinate width
  localparam int DW = 2 * CW + 1;   // distance width, one extra bit so dx^2+dy^2 never wraps

  // per-slot state; occupied slots are contiguous from slot 0 and sorted ascending
  logic [N_NEIGHBOUR-1:0] r_occ;
  logic [DW-1:0]          r_dist [N_NEIGHBOUR];
  logic [LABEL-1:0]       r_lbl  [N_NEIGHBOUR];

  logic [N_NEIGHBOUR-1:0] w_nxt_occ;
  logic [DW-1:0]          w_nxt_dist [N_NEIGHBOUR];
  logic [LABEL-1:0]       w_nxt_lbl  [N_NEIGHBOUR];

  logic [CW-1:0]   w_ax, w_ay, w_bx, w_by;
  logic [CW-1:0]   w_dx, w_dy;
  logic [2*CW-1:0] w_dx2, w_dy2;
  logic [DW-1:0]   w_dist;
  logic [N_NEIGHBOUR-1:0] w_gt;     // slot is empty or strictly farther than the new sample
  logic            w_prev_gt;

  assign w_ax = A[DATA_W-1:CW];
  assign w_ay = A[CW-1:0];
  assign w_bx = B[DATA_W-1:CW];
  assign w_by = B[CW-1:0];

  // absolute coordinate differences
  assign w_dx = (w_ax >= w_bx) ? (w_ax - w_bx) : (w_bx - w_ax);
  assign w_dy = (w_ay >= w_by) ? (w_ay - w_by) : (w_by - w_ay);

  // full-width squares and sum
  assign w_dx2  = {{CW{1'b0}}, w_dx} * {{CW{1'b0}}, w_dx};
  assign w_dy2  = {{CW{1'b0}}, w_dy} * {{CW{1'b0}}, w_dy};
  assign w_dist = {1'b0, w_dx2} + {1'b0, w_dy2};

  // parallel compare of every slot against the incoming distance; strict > keeps ties stable
  always_comb begin
    for (int i = 0; i < N_NEIGHBOUR; i++) begin
      w_gt[i] = !r_occ[i] || (r_dist[i] > w_dist);
    end
  end

  // next-state per slot: clear, write new entry at insertion point, shift up above it, else hold
  always_comb begin
    w_prev_gt = 1'b0;
    for (int i = 0; i < N_NEIGHBOUR; i++) begin
      w_nxt_occ[i]  = r_occ[i];
      w_nxt_dist[i] = r_dist[i];
      w_nxt_lbl[i]  = r_lbl[i];
      if (!start) begin
        w_nxt_occ[i]  = 1'b0;
        w_nxt_dist[i] = '0;
        w_nxt_lbl[i]  = '0;
      end else if (valid && w_gt[i]) begin
        if (w_prev_gt) begin
          // monotonic w_gt means the slot below is also displaced: take its old content
          w_nxt_occ[i]  = r_occ[i-1];
          w_nxt_dist[i] = r_dist[i-1];
          w_nxt_lbl[i]  = r_lbl[i-1];
        end else begin
          w_nxt_occ[i]  = 1'b1;
          w_nxt_dist[i] = w_dist;
          w_nxt_lbl[i]  = label;
        end
      end
      w_prev_gt = w_gt[i];
    end
  end

  // slot registers with asynchronous clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_occ <= '0;
      for (int i = 0; i < N_NEIGHBOUR; i++) begin
        r_dist[i] <= '0;
        r_lbl[i]  <= '0;
      end
    end else begin
      r_occ <= w_nxt_occ;
      for (int i = 0; i < N_NEIGHBOUR; i++) begin
        r_dist[i] <= w_nxt_dist[i];
        r_lbl[i]  <= w_nxt_lbl[i];
      end
    end
  end

  // labels of the sorted list; empty slots read as zero
  always_comb begin
    Neighbour_info = '0;
    for (int i = 0; i < N_NEIGHBOUR; i++) begin
      Neighbour_info[LABEL*i +: LABEL] = r_occ[i] ? r_lbl[i] : '0;
    end
  end

endmodule

// File: tb/tb_knn_core_unit.sv
// Bench for knn_core_unit: reference sorted-list model feeds an expected-output queue per driven cycle.
// Latency: one comparison just after each active edge.
// Backpressure: none in the design; the bench drives one sample per clock.
module tb_knn_core_unit;

  localparam int DATA_W = 32;
  localparam int LABEL  = 8;
  localparam int NN     = 4;

  logic                  clk;
  logic                  rst;
  logic                  start;
  logic                  valid;
  logic [DATA_W-1:0]     A;
  logic [DATA_W-1:0]     B;
  logic [LABEL-1:0]      label;
  logic [LABEL*NN-1:0]   Neighbour_info;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [32:0]      d;
    logic [LABEL-1:0] l;
  } ent_t;

  ent_t              mdl[$];
  logic [LABEL*NN-1:0] exp_q[$];

  knn_core_unit #(.DATA_W(DATA_W), .LABEL(LABEL), .N_NEIGHBOUR(NN)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .valid          (valid),
    .A              (A),
    .B              (B),
    .label          (label),
    .Neighbour_info (Neighbour_info)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] pt(input int x, input int y);
    logic [15:0] px;
    logic [15:0] py;
    px = 16'(x);
    py = 16'(y);
    return {px, py};
  endfunction

  function automatic logic [32:0] mdist(input logic [31:0] a, input logic [31:0] b);
    longint ax, ay, bx, by, dx, dy;
    ax = longint'(a[31:16]); ay = longint'(a[15:0]);
    bx = longint'(b[31:16]); by = longint'(b[15:0]);
    dx = (ax > bx) ? ax - bx : bx - ax;
    dy = (ay > by) ? ay - by : by - ay;
    return 33'(dx * dx + dy * dy);
  endfunction

  function automatic logic [LABEL*NN-1:0] pack_model();
    logic [LABEL*NN-1:0] v;
    v = '0;
    for (int i = 0; i < mdl.size(); i++) v[LABEL*i +: LABEL] = mdl[i].l;
    return v;
  endfunction

  function automatic void model_insert(input logic [32:0] d, input logic [LABEL-1:0] l);
    int   p;
    ent_t e;
    p = mdl.size();
    for (int i = 0; i < mdl.size(); i++) begin
      if (mdl[i].d > d) begin
        p = i;
        break;
      end
    end
    if (p < NN) begin
      e.d = d;
      e.l = l;
      mdl.insert(p, e);
      if (mdl.size() > NN) void'(mdl.pop_back());
    end
  endfunction

  // Drive one cycle, push the model's expectation, compare just after the edge.
  task automatic step(input logic s, input logic v, input logic [31:0] a, input logic [31:0] b,
                      input logic [LABEL-1:0] l, input string nm);
    logic [LABEL*NN-1:0] exp_v;
    start = s; valid = v; A = a; B = b; label = l;
    if (!s) mdl.delete();
    else if (v) model_insert(mdist(a, b), l);
    exp_q.push_back(pack_model());
    @(posedge clk);
    #1;
    exp_v = exp_q.pop_front();
    checks++;
    if (Neighbour_info !== exp_v) begin
      failures++;
      $display("FAIL %s: Neighbour_info=%h expected=%h", nm, Neighbour_info, exp_v);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start = 1'b1; valid = 1'b1;
      A = $urandom; B = $urandom; label = 8'($urandom);
      @(posedge clk);
      #1;
      checks++;
      if (Neighbour_info !== '0) begin
        failures++;
        $display("FAIL reset_hold: Neighbour_info=%h expected=0", Neighbour_info);
      end
    end
    rst = 1'b1;
    mdl.delete();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, $urandom, $urandom, 8'($urandom), "reset_idle");
  endtask

  task automatic test_basic_sort();
    logic [31:0] a;
    a = pt(10, 10);
    step(1'b1, 1'b1, a, pt(11, 11), 8'd1, "sort_d2");
    step(1'b1, 1'b1, a, pt(15, 15), 8'd2, "sort_d50");
    step(1'b1, 1'b1, a, pt(12, 12), 8'd1, "sort_d8");
    step(1'b1, 1'b1, a, pt(12, 10), 8'd1, "sort_d4");
    checks++;
    if (Neighbour_info !== 32'h02010101) begin
      failures++;
      $display("FAIL sort_final: Neighbour_info=%h expected=02010101", Neighbour_info);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] a;
    a = pt(10, 10);
    step(1'b1, 1'b1, a, pt(20, 10), 8'd3, "discard_d100");
    step(1'b1, 1'b1, a, pt(10, 10), 8'd5, "insert_d0");
    checks++;
    if (Neighbour_info !== 32'h01010105) begin
      failures++;
      $display("FAIL overflow_final: Neighbour_info=%h expected=01010105", Neighbour_info);
    end
  endtask

  task automatic test_ties_gating();
    logic [31:0] a;
    a = pt(10, 10);
    step(1'b0, 1'b0, a, a, 8'd0, "tie_clear");
    step(1'b1, 1'b1, a, pt(12, 10), 8'd7, "tie_first");
    step(1'b1, 1'b1, a, pt(10, 8),  8'd9, "tie_second");
    step(1'b1, 1'b1, a, pt(13, 10), 8'd6, "tie_farther");
    step(1'b1, 1'b0, a, pt(10, 10), 8'd8, "valid_low");
    checks++;
    if (Neighbour_info !== 32'h00060907) begin
      failures++;
      $display("FAIL tie_order: Neighbour_info=%h expected=00060907", Neighbour_info);
    end
  endtask

  task automatic test_clear_extremes();
    logic [31:0] a;
    a = pt(0, 0);
    step(1'b0, 1'b1, a, pt(1, 1), 8'd3, "clear_priority");
    step(1'b1, 1'b1, a, pt(65535, 65535), 8'd4, "extreme_max");
    checks++;
    if (Neighbour_info !== 32'h00000004) begin
      failures++;
      $display("FAIL extreme_slot0: Neighbour_info=%h expected=00000004", Neighbour_info);
    end
    // 0xFFFE0001 sorts before 0x1FFFC0002 only if the top distance bit is kept
    step(1'b1, 1'b1, a, pt(0, 65535), 8'd6, "extreme_no_wrap");
    step(1'b1, 1'b1, pt(65535, 65535), pt(0, 0), 8'd2, "extreme_tie_max");
  endtask

  task automatic test_async_reset();
    logic [31:0] a;
    a = pt(100, 200);
    step(1'b0, 1'b0, a, a, 8'd0, "async_pre_clear");
    step(1'b1, 1'b1, a, pt(101, 200), 8'd11, "async_ins1");
    step(1'b1, 1'b1, a, pt(90, 190),  8'd12, "async_ins2");
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (Neighbour_info !== '0) begin
      failures++;
      $display("FAIL async_reset: Neighbour_info=%h expected=0", Neighbour_info);
    end
    mdl.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(1'b1, 1'b1, a, pt(100, 201), 8'd13, "after_reset");
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; valid = 1'b0; A = '0; B = '0; label = '0;
    #1;
    checks++;
    if (Neighbour_info !== '0) begin
      failures++;
      $display("FAIL reset_initial: Neighbour_info=%h expected=0", Neighbour_info);
    end
    test_reset();
    test_basic_sort();
    test_overflow();
    test_ties_gating();
    test_clear_extremes();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
